// File: rtl/wback_regfile_pkg.sv
// Shared register-file types plus the writeback record handed over by the memory stage.
// Consumed by wback_regfile and rf_read_port; the bypass feature is selected with WBACK_REGFILE_BYPASS_EN.
package RegFilePkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_WIDTH  = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;
endpackage

package PipelineReg;
  import RegFilePkg::*;

  typedef struct packed {
    logic      RegWrite;
    reg_addr_t rd;
    reg_data_t final_out;
  } WBACK_STATE;
endpackage

// File: rtl/wback_regfile_read_port.sv
// One combinational source-operand read port: x0 forced to zero, optional write-through bypass
// (enabled by defining WBACK_REGFILE_BYPASS_EN).
module rf_read_port
#(
  parameter int DATA_WIDTH = RegFilePkg::DATA_WIDTH,
  parameter int REG_ADDR_W = RegFilePkg::REG_ADDR_W
)
(
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
`ifdef WBACK_REGFILE_BYPASS_EN
  input  logic                  i_wr_en,
  input  logic [REG_ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
`endif
  output logic [DATA_WIDTH-1:0] o_data
);
  import RegFilePkg::*;

  always_comb begin
    o_data = i_rf_data;
`ifdef WBACK_REGFILE_BYPASS_EN
    // i_wr_en already excludes rd==0, but the zero check below covers x0 regardless.
    if (i_wr_en && (i_wr_addr == i_addr)) begin
      o_data = i_wr_data;
    end
`endif
    if (i_addr == '0) begin
      o_data = '0;
    end
  end
endmodule

// File: rtl/wback_regfile.sv
// Writeback stage and integer register file: commits final_out to rd, serves two reads,
// counts committed writes. Build option: WBACK_REGFILE_BYPASS_EN adds write-through bypass.
module wback_regfile
#(
  parameter int DATA_WIDTH = RegFilePkg::DATA_WIDTH,
  parameter int NUM_REGS   = RegFilePkg::NUM_REGS,
  parameter int REG_ADDR_W = RegFilePkg::REG_ADDR_W,
  parameter int CNT_WIDTH  = RegFilePkg::CNT_WIDTH
)
(
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  PipelineReg::WBACK_STATE  i_wback_state,
  input  logic [REG_ADDR_W-1:0]    i_rs1_addr,
  input  logic [REG_ADDR_W-1:0]    i_rs2_addr,
  output logic [DATA_WIDTH-1:0]    o_rs1_data,
  output logic [DATA_WIDTH-1:0]    o_rs2_data,
  output logic [CNT_WIDTH-1:0]     o_wr_count,
  output logic [REG_ADDR_W-1:0]    o_last_rd
);
  import RegFilePkg::*;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
  logic [REG_ADDR_W-1:0] last_rd_q, last_rd_d;

  reg_addr_t wr_addr;
  reg_data_t wr_data;
  logic      commit;

  assign wr_addr = i_wback_state.rd;
  assign wr_data = i_wback_state.final_out;
  // Writes to x0 are architectural no-ops: no storage, count or last_rd update.
  assign commit  = i_wback_state.RegWrite && (wr_addr != '0);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    last_rd_d  = last_rd_q;
    if (commit) begin
      regs_d[wr_addr] = wr_data;
      wr_count_d      = wr_count_q + CNT_WIDTH'(1);
      last_rd_d       = wr_addr;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
      last_rd_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_count_q <= wr_count_d;
      last_rd_q  <= last_rd_d;
    end
  end

  logic [REG_ADDR_W-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];

  assign rd_addr[0] = i_rs1_addr;
  assign rd_addr[1] = i_rs2_addr;

  for (genvar gi = 0; gi < 2; gi++) begin : g_read
    rf_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_ADDR_W (REG_ADDR_W)
    ) u_port (
      .i_addr    (rd_addr[gi]),
      .i_rf_data (regs_q[rd_addr[gi]]),
`ifdef WBACK_REGFILE_BYPASS_EN
      .i_wr_en   (commit),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
`endif
      .o_data    (rd_data[gi])
    );
  end

  assign o_rs1_data = rd_data[0];
  assign o_rs2_data = rd_data[1];
  assign o_wr_count = wr_count_q;
  assign o_last_rd  = last_rd_q;
endmodule

// File: tb/tb_wback_regfile.sv
// Self-checking bench for wback_regfile: directed table, same-cycle hazard, counter wrap
// (via a narrow-counter instance), randomized run against a reference model, reset mid-operation.
module tb_wback_regfile;
`ifdef WBACK_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                    clk;
  logic                    rst_n;
  PipelineReg::WBACK_STATE wb;
  logic [4:0]              rs1, rs2;
  logic [31:0]             rs1_data, rs2_data, wr_count;
  logic [4:0]              last_rd;
  logic [31:0]             s_rs1_data, s_rs2_data;
  logic [3:0]              s_wr_count;
  logic [4:0]              s_last_rd;

  wback_regfile dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wback_state(wb),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
    .o_wr_count(wr_count), .o_last_rd(last_rd)
  );

  wback_regfile #(.CNT_WIDTH(4)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_wback_state(wb),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .o_rs1_data(s_rs1_data), .o_rs2_data(s_rs2_data),
    .o_wr_count(s_wr_count), .o_last_rd(s_last_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] mem [32];
  int unsigned m_cnt;
  logic [4:0]  m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    m_cnt  = 0;
    m_last = 5'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && wb.RegWrite && wb.rd != 5'd0 && a == wb.rd) return wb.final_out;
    return mem[a];
  endfunction

  task automatic model_edge();
    if (wb.RegWrite && wb.rd != 5'd0) begin
      mem[wb.rd] = wb.final_out;
      m_cnt++;
      m_last = wb.rd;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, " wr_count"}, wr_count, m_cnt);
    check({tag, " small_count"}, {28'h0, s_wr_count}, m_cnt % 16);
    check({tag, " last_rd"}, {27'h0, last_rd}, {27'h0, m_last});
  endtask

  task automatic commit(input logic [4:0] rd, input logic [31:0] data);
    @(negedge clk);
    wb.RegWrite = 1'b1; wb.rd = rd; wb.final_out = data;
    @(posedge clk);
    model_edge();
    #1;
    wb.RegWrite = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ecnt;
    logic [4:0]  elast;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        32'd1, 5'd5};
    vecs[1] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5, 32'h0,        32'hDEADBEEF, 32'd1, 5'd5};
    vecs[2] = '{1'b0, 5'd6,  32'hCAFEF00D, 5'd6,  5'd5, 32'h0,        32'hDEADBEEF, 32'd1, 5'd5};
    vecs[3] = '{1'b1, 5'd7,  32'h00000011, 5'd7,  5'd5, 32'h00000011, 32'hDEADBEEF, 32'd2, 5'd7};
    vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd7, 32'hFFFFFFFF, 32'h00000011, 32'd3, 5'd31};
    vecs[5] = '{1'b1, 5'd5,  32'h00000000, 5'd5,  5'd5, 32'h0,        32'h0,        32'd4, 5'd5};

    rst_n = 1'b0;
    wb = '0;
    rs1 = 5'd1; rs2 = 5'd31;
    model_reset();

    // Reset applied before any clock edge
    #1;
    check("reset rs1", rs1_data, 32'h0);
    check("reset rs2", rs2_data, 32'h0);
    check("reset wr_count", wr_count, 32'h0);
    check("reset last_rd", {27'h0, last_rd}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wb.RegWrite = vecs[i].we; wb.rd = vecs[i].rd; wb.final_out = vecs[i].data;
      rs1 = vecs[i].a1; rs2 = vecs[i].a2;
      @(posedge clk);
      model_edge();
      #1;
      wb.RegWrite = 1'b0;
      #1;
      check($sformatf("vec%0d rs1", i), rs1_data, vecs[i].e1);
      check($sformatf("vec%0d rs2", i), rs2_data, vecs[i].e2);
      check($sformatf("vec%0d wr_count", i), wr_count, vecs[i].ecnt);
      check($sformatf("vec%0d last_rd", i), {27'h0, last_rd}, {27'h0, vecs[i].elast});
    end

    // Same-cycle read of the register being written (reg7 holds 0x11)
    @(negedge clk);
    wb.RegWrite = 1'b1; wb.rd = 5'd7; wb.final_out = 32'hA5A5A5A5;
    rs1 = 5'd7; rs2 = 5'd7;
    #1;
    check("samecyc pre rs1", rs1_data, BYP ? 32'hA5A5A5A5 : 32'h00000011);
    check("samecyc pre rs2", rs2_data, BYP ? 32'hA5A5A5A5 : 32'h00000011);
    @(posedge clk);
    model_edge();
    #1;
    check("samecyc post rs1", rs1_data, 32'hA5A5A5A5);
    check("samecyc post rs2", rs2_data, 32'hA5A5A5A5);
    wb.RegWrite = 1'b0;
    check_state("samecyc");

    // Narrow counter: drive it to its max, then one more commit to rd=3 wraps it
    for (int i = 0; i < 10; i++) commit(5'd3, 32'h3000_0000 + i);
    check("wrap pre small_count", {28'h0, s_wr_count}, 32'hF);
    commit(5'd3, 32'h33333333);
    rs1 = 5'd3; #1;
    check("wrap small_count", {28'h0, s_wr_count}, 32'h0);
    check("wrap wr_count", wr_count, 32'd16);
    check("wrap small rs1", s_rs1_data, 32'h33333333);
    check("wrap rs1", rs1_data, 32'h33333333);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      wb.RegWrite  = ($urandom_range(0, 9) < 7);
      wb.rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      wb.final_out = $urandom;
      rs1 = ($urandom_range(0, 3) == 0) ? wb.rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rs1   : 5'($urandom_range(0, 31));
      #1;
      check($sformatf("rand%0d rs1", n), rs1_data, model_read(rs1));
      check($sformatf("rand%0d rs2", n), rs2_data, model_read(rs2));
      @(posedge clk);
      model_edge();
      #1;
      check_state($sformatf("rand%0d", n));
    end

    // Fill x1..x31 with their index, then reset between edges
    for (int i = 1; i < 32; i++) commit(5'(i), 32'(i));
    rs1 = 5'd17; rs2 = 5'd31; #1;
    check("fill rs1", rs1_data, 32'd17);
    check("fill rs2", rs2_data, 32'd31);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int a = 1; a < 32; a++) begin
      rs1 = 5'(a); rs2 = 5'(32 - a);
      #0.1;
      check($sformatf("rstmid rs1 a%0d", a), rs1_data, 32'h0);
      check($sformatf("rstmid rs2 a%0d", a), rs2_data, 32'h0);
    end
    check_state("rstmid");
    wb.RegWrite = 1'b1; wb.rd = 5'd9; wb.final_out = 32'h99999999;
    @(posedge clk);
    #1;
    wb.RegWrite = 1'b0;
    rs1 = 5'd9; #1;
    check("rst write rs1", rs1_data, 32'h0);
    check_state("rst write");

    @(negedge clk);
    rst_n = 1'b1;
    commit(5'd12, 32'h0BADF00D);
    rs1 = 5'd12; rs2 = 5'd9; #1;
    check("post rst rs1", rs1_data, 32'h0BADF00D);
    check("post rst rs2", rs2_data, 32'h0);
    check_state("post rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wback_regfile.md
Name: wback_regfile

Overview:
- Writeback stage and integer register file of the 32-bit RISC-V pipeline.
- Consumes the WBACK_STATE record produced by the data-memory stage and commits final_out to register rd.
- Serves the two decode-stage source-operand reads.
- Keeps a committed-write counter for debug and performance monitoring.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.
- REG_ADDR_W, 5, register index width; must equal $clog2(NUM_REGS).
- CNT_WIDTH, 32, width of the committed-write counter.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_wback_state  input  PipelineReg::WBACK_STATE  writeback record from the memory stage: RegWrite, rd, final_out.
- i_rs1_addr  input  REG_ADDR_W  source register 1 index from decode.
- i_rs2_addr  input  REG_ADDR_W  source register 2 index from decode.
- o_rs1_data  output  DATA_WIDTH  source register 1 value.
- o_rs2_data  output  DATA_WIDTH  source register 2 value.
- o_wr_count  output  CNT_WIDTH  number of committed register writes.
- o_last_rd  output  REG_ADDR_W  rd of the most recent committed write.

Behaviour:
- Reset: asserting i_rst_n low immediately, with no clock, clears all registers, o_wr_count and o_last_rd to 0.
  - o_rs1_data and o_rs2_data follow the cleared array combinationally, so they read 0.
  - Deassertion is synchronised externally; the first update is on the first rising edge after deassertion.
- Commit condition: RegWrite==1 and rd!=0.
  - On a rising edge where the condition holds: reg[rd] <= final_out, o_wr_count <= o_wr_count+1, o_last_rd <= rd.
  - Write latency is one edge.
- x0 writes: RegWrite==1 with rd==0 changes no state. reg[0] stays 0, the counter does not increment and o_last_rd holds its value.
- RegWrite==0: no state change, regardless of rd and final_out.
- Reads: combinational and asynchronous.
  - o_rsN_data = 0 when i_rsN_addr==0.
  - Otherwise o_rsN_data = reg[i_rsN_addr], subject to the bypass rule under Optional Feature.
- Both ports may read the same index at once; both return the same value.
- Counter wraps modulo 2^CNT_WIDTH: 0xFFFFFFFF + 1 -> 0x00000000. There is no saturation and no flag.
- Reset mid-write: reset wins. A write presented on an edge while i_rst_n is low is discarded.
- No stall input. The upstream stage presents RegWrite=0 for bubbles.
- No X propagation: every output is driven from a defined value whenever reset has been applied.

Optional Feature:
- Macro: WBACK_REGFILE_BYPASS_EN.
- Defined: write-through bypass. When the commit condition holds and i_rsN_addr==rd, o_rsN_data = final_out in the same cycle, before the edge. This removes the WB->ID hazard.
- Undefined: reads always return the stored array value. A same-cycle read of rd returns the pre-write value, and the hazard unit must stall one cycle.
- Counter and o_last_rd behaviour are identical in both builds.

Decomposition:
- Package RegFilePkg holds:
  - localparams NUM_REGS=32 and REG_ADDR_W=5;
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]);
  - typedef reg_data_t (logic [DATA_WIDTH-1:0]).
- WBACK_STATE remains in PipelineReg and is not redefined.
- Sub-module rf_read_port is instantiated twice. It contains the x0 zero check and the bypass mux guarded by WBACK_REGFILE_BYPASS_EN.
- Storage, commit logic and counter stay in wback_regfile.

Test Plan:
- Reset check: hold i_rst_n=0 with no clock edge, read addresses 1 and 31 -> both outputs 0, o_wr_count=0, o_last_rd=0.
- Basic write: commit RegWrite=1, rd=5, final_out=0xDEADBEEF, then read rs1=5 -> 0xDEADBEEF; o_wr_count=1; o_last_rd=5.
- x0 write: RegWrite=1, rd=0, final_out=0x12345678 -> rs1=0 reads 0, o_wr_count unchanged, o_last_rd unchanged.
- Same-cycle read of the written register: present rd=7, final_out=0xA5A5A5A5 (reg7 previously 0x11) with rs1=rs2=7 before the edge.
  - Bypass build: both ports read 0xA5A5A5A5 before the edge.
  - Non-bypass build: both read 0x11 before the edge and 0xA5A5A5A5 after it.
- Counter wrap: force o_wr_count=0xFFFFFFFF, commit rd=3 -> o_wr_count=0x00000000 and reg3 is updated.
- Reset mid-operation: fill x1..x31 with i, then assert i_rst_n=0 between edges -> all reads return 0 immediately; an edge with RegWrite=1, rd=9 while reset is low leaves reg9=0.
